regbus: RTL

Parametrised ARM register bridge, successor to the single-window `regs` decoder. Terminates the 32-bit ARM register port, serves a bank of local read/write control words and read-only status words, and forwards 1 MiB address windows to `NCH` downstream channels over a req/ack/err handshake. Unlike its predecessor, every access is acknowledged: unmapped addresses and timed-out channels complete with `armerr`. Local writes honour byte strobes.

---
 rtl/regbus.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/regbus.sv
// ----------------------------------------------------------------------------
// regbus -- ARM register bridge.
//
// Terminates a 32-bit ARM register port. Window 0 (armaddr[23:20] == 0) holds
// NCTL byte-writable control words at word offsets 0..NCTL-1 and NSTS
// read-only status words at word offsets 0x200..0x200+NSTS-1. Windows
// 1..NCH forward the access to a downstream channel over a req/ack/err
// handshake. Every access completes with a one-cycle o_armack pulse; unmapped
// offsets, unused windows and status writes complete with o_armerr = 1.
//
// Optional feature: define REGBUS_TIMEOUT_EN to build a TOW-bit channel
// watchdog that completes a channel access with an error after 2**TOW-1
// cycles without an acknowledge. Without it, a channel access waits forever.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_armaddr            byte address: [23:20] window, [19:0] offset
//   i_armwdata/wstrb/wr  write data, byte-lane enables, 1 = write
//   i_armreq             request; a rising edge starts a transaction
//   o_armack             one-cycle completion pulse
//   o_armerr, o_armrdata completion status / read data, held between acks
//   o_ctl                flattened control words, word k at [32k+31:32k]
//   i_sts                flattened status words
//   o_chaddr/chwdata/chwstrb/chwr  shared channel request fields
//   o_chreq              per-channel request, one-hot or zero
//   i_chack, i_cherr     per-channel completion and error
//   i_chrdata            flattened per-channel read data
// ----------------------------------------------------------------------------
module regbus #(
    parameter int NCTL = 16,
    parameter int NSTS = 4,
    parameter int NCH  = 2,
    parameter int TOW  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [31:0]         i_armaddr,
    input  logic [31:0]         i_armwdata,
    input  logic [3:0]          i_armwstrb,
    input  logic                i_armwr,
    input  logic                i_armreq,
    output logic                o_armack,
    output logic                o_armerr,
    output logic [31:0]         o_armrdata,
    output logic [32*NCTL-1:0]  o_ctl,
    input  logic [32*NSTS-1:0]  i_sts,
    output logic [19:0]         o_chaddr,
    output logic [31:0]         o_chwdata,
    output logic [3:0]          o_chwstrb,
    output logic                o_chwr,
    output logic [NCH-1:0]      o_chreq,
    input  logic [NCH-1:0]      i_chack,
    input  logic [NCH-1:0]      i_cherr,
    input  logic [32*NCH-1:0]   i_chrdata
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_CHAN  = 1'b1;
    localparam logic [17:0] STS_BASE = 18'h200;
    localparam logic [17:0] STS_END  = 18'(512 + NSTS);

    // TOW only sizes the optional watchdog; this empty guard keeps the
    // parameter referenced in every build. TOW must be at least 1.
    if (TOW < 1) begin : g_tow_range
    end

    logic [0:0]  r_state;
    logic        r_armreq0;
    logic        r_armack;
    logic        r_armerr;
    logic [31:0] r_armrdata;
    logic [31:0] r_ctl [NCTL];
    logic [19:0] r_chaddr;
    logic [31:0] r_chwdata;
    logic [3:0]  r_chwstrb;
    logic        r_chwr;
    logic [NCH-1:0] r_chreq;

    logic [3:0]  w_win;
    logic [17:0] w_word;
    logic        w_start;
    logic        w_is_ctl;
    logic        w_is_sts;
    logic        w_is_chan;
    logic [31:0] w_ctl_rd;
    logic [31:0] w_sts_rd;
    logic [NCH-1:0] w_chsel;
    logic        w_ch_ack;
    logic        w_ch_err;
    logic [31:0] w_ch_rdata;
    logic        w_unused_addr;

    assign w_win         = i_armaddr[23:20];
    assign w_word        = i_armaddr[19:2];
    assign w_unused_addr = ^{i_armaddr[31:24], i_armaddr[1:0]};

    // Only a rising edge of armreq seen while idle starts a transaction.
    assign w_start   = i_armreq && !r_armreq0 && (r_state == ST_IDLE);
    assign w_is_ctl  = (w_word < 18'(NCTL));
    assign w_is_sts  = (w_word >= STS_BASE) && (w_word < STS_END);
    assign w_is_chan = (w_win != 4'd0) && (int'(w_win) <= NCH);

    // Local read muxes and channel select.
    // NOTE: every always_comb output is given a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        w_ctl_rd = '0;
        for (int k = 0; k < NCTL; k++) begin
            if (w_word == 18'(k)) w_ctl_rd = r_ctl[k];
        end
        w_sts_rd = '0;
        for (int k = 0; k < NSTS; k++) begin
            if (w_word == 18'(512 + k)) w_sts_rd = i_sts[32*k +: 32];
        end
        w_chsel = '0;
        for (int k = 0; k < NCH; k++) begin
            w_chsel[k] = (w_win == 4'(k + 1));
        end
    end

    // Completion of the requested channel; acks from other channels are
    // masked off by the one-hot request register.
    always_comb begin
        w_ch_ack   = |(i_chack & r_chreq);
        w_ch_err   = |(i_cherr & r_chreq);
        w_ch_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_chreq[k]) w_ch_rdata = w_ch_rdata | i_chrdata[32*k +: 32];
        end
    end

`ifdef REGBUS_TIMEOUT_EN
    // Expiry is taken on the edge where the counter would reach 2**TOW-1,
    // so the error ack lands 2**TOW-1 cycles after CHAN entry.
    localparam logic [TOW-1:0] TMO_LAST = ~TOW'(1);
    logic [TOW-1:0] r_tmo;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Held high so a request already asserted at reset release is not
            // taken as a rising edge.
            r_armreq0  <= 1'b1;
            r_state    <= ST_IDLE;
            r_armack   <= 1'b0;
            r_armerr   <= 1'b0;
            r_armrdata <= '0;
            r_chaddr   <= '0;
            r_chwdata  <= '0;
            r_chwstrb  <= '0;
            r_chwr     <= 1'b0;
            r_chreq    <= '0;
            // NOTE: the control bank is flops with a defined reset value,
            // not RAM, so every word is cleared here.
            for (int k = 0; k < NCTL; k++) r_ctl[k] <= '0;
`ifdef REGBUS_TIMEOUT_EN
            r_tmo      <= '0;
`endif
        end else begin
            r_armreq0 <= i_armreq;
            r_armack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_win == 4'd0) begin
                            r_armack <= 1'b1;
                            if (w_is_ctl) begin
                                r_armerr   <= 1'b0;
                                r_armrdata <= w_ctl_rd;
                                if (i_armwr) begin
                                    for (int k = 0; k < NCTL; k++) begin
                                        for (int b = 0; b < 4; b++) begin
                                            if (w_word == 18'(k) && i_armwstrb[b])
                                                r_ctl[k][8*b +: 8] <= i_armwdata[8*b +: 8];
                                        end
                                    end
                                end
                            end else if (w_is_sts) begin
                                // Status words are read-only: writes only error.
                                r_armerr   <= i_armwr;
                                r_armrdata <= w_sts_rd;
                            end else begin
                                r_armerr   <= 1'b1;
                                r_armrdata <= 32'hFFFF_FFFF;
                            end
                        end else if (w_is_chan) begin
                            r_chaddr  <= i_armaddr[19:0];
                            r_chwdata <= i_armwdata;
                            r_chwstrb <= i_armwstrb;
                            r_chwr    <= i_armwr;
                            r_chreq   <= w_chsel;
                            r_state   <= ST_CHAN;
`ifdef REGBUS_TIMEOUT_EN
                            r_tmo     <= '0;
`endif
                        end else begin
                            r_armack   <= 1'b1;
                            r_armerr   <= 1'b1;
                            r_armrdata <= 32'hFFFF_FFFF;
                        end
                    end
                end
                ST_CHAN: begin
                    // An acknowledge on the expiry cycle takes priority.
                    if (w_ch_ack) begin
                        r_chreq    <= '0;
                        r_armack   <= 1'b1;
                        r_armerr   <= w_ch_err;
                        r_armrdata <= w_ch_rdata;
                        r_state    <= ST_IDLE;
                    end
`ifdef REGBUS_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_chreq    <= '0;
                        r_armack   <= 1'b1;
                        r_armerr   <= 1'b1;
                        r_armrdata <= 32'hFFFF_FFFF;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NCTL; k++) begin : g_ctl_out
        assign o_ctl[32*k +: 32] = r_ctl[k];
    end

    assign o_armack   = r_armack;
    assign o_armerr   = r_armerr;
    assign o_armrdata = r_armrdata;
    assign o_chaddr   = r_chaddr;
    assign o_chwdata  = r_chwdata;
    assign o_chwstrb  = r_chwstrb;
    assign o_chwr     = r_chwr;
    assign o_chreq    = r_chreq;

endmodule
